// File: rtl/uart_pkg.sv
// Shared types and constants for the UART: FSM state encodings, TX FIFO depth
// and the baud tick divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int TX_FIFO_DEPTH = 4;

  // System clocks per oversample tick, truncated toward zero.
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: counts 0..TICK_DIV-1 and emits a
// one-cycle tick on the last count. Shared by the TX and RX paths.
module uart_baud_gen #(
  parameter int TICK_DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/top_uart.sv
// Full-duplex 8N1 UART: 4-entry TX byte FIFO feeding a serializer, and a
// 2-flop-synchronized deserializer feeding a single RX output register.
module top_uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BIT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_valid,
  input  logic [DATA_BIT-1:0] tx_data,
  output logic                tx_ready,
  input  logic                rx_ready,
  output logic                rx_valid,
  output logic [DATA_BIT-1:0] rx_data,
  output logic                tx_serial,
  input  logic                rx_serial
);

  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(TX_FIFO_DEPTH);

  logic tick;

  uart_baud_gen #(.TICK_DIV(TICK_DIV)) u_baud_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // ---------------- TX FIFO ----------------
  logic [DATA_BIT-1:0] fifo_mem [TX_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         fifo_count, fifo_count_next;
  logic                fifo_push, fifo_empty, tx_pop;

  assign fifo_push  = tx_valid && tx_ready;
  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    fifo_count_next = fifo_count;
    unique case ({fifo_push, tx_pop})
      2'b10:   fifo_count_next = fifo_count + (PW + 1)'(1);
      2'b01:   fifo_count_next = fifo_count - (PW + 1)'(1);
      default: fifo_count_next = fifo_count;
    endcase
  end

  // NOTE: storage array has no reset; the pointers and count define emptiness,
  // so stale contents are never read and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (tx_pop)    rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count_next;
      tx_ready   <= (fifo_count_next != FIFO_FULL);
    end
  end

  // ---------------- TX serializer ----------------
  tx_state_t           tx_state, tx_state_next;
  logic [OW-1:0]       tx_cnt, tx_cnt_next;
  logic [BW-1:0]       tx_bit, tx_bit_next;
  logic [DATA_BIT-1:0] tx_shift, tx_shift_next;
  logic                tx_serial_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_serial <= 1'b1;
    end else begin
      // NOTE: state and datapath registers take non-blocking assignments only;
      // the combinational block below uses blocking assignments.
      tx_state  <= tx_state_next;
      tx_cnt    <= tx_cnt_next;
      tx_bit    <= tx_bit_next;
      tx_shift  <= tx_shift_next;
      tx_serial <= tx_serial_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    tx_state_next  = tx_state;
    tx_cnt_next    = tx_cnt;
    tx_bit_next    = tx_bit;
    tx_shift_next  = tx_shift;
    tx_serial_next = tx_serial;
    tx_pop         = 1'b0;
    if (tick) begin
      unique case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_pop         = 1'b1;
            tx_shift_next  = fifo_mem[rd_ptr];
            tx_serial_next = 1'b0;
            tx_cnt_next    = '0;
            tx_state_next  = TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == OS_LAST) begin
            tx_cnt_next    = '0;
            tx_bit_next    = '0;
            tx_serial_next = tx_shift[0];
            tx_state_next  = TX_DATA;
          end else begin
            tx_cnt_next = tx_cnt + OW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == OS_LAST) begin
            tx_cnt_next = '0;
            if (tx_bit == BIT_LAST) begin
              tx_serial_next = 1'b1;
              tx_state_next  = TX_STOP;
            end else begin
              tx_shift_next  = {1'b0, tx_shift[DATA_BIT-1:1]};
              tx_serial_next = tx_shift_next[0];
              tx_bit_next    = tx_bit + BW'(1);
            end
          end else begin
            tx_cnt_next = tx_cnt + OW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == OS_LAST) begin
            tx_cnt_next = '0;
            // A queued byte starts immediately, giving gapless frames.
            if (!fifo_empty) begin
              tx_pop         = 1'b1;
              tx_shift_next  = fifo_mem[rd_ptr];
              tx_serial_next = 1'b0;
              tx_state_next  = TX_START;
            end else begin
              tx_state_next  = TX_IDLE;
            end
          end else begin
            tx_cnt_next = tx_cnt + OW'(1);
          end
        end
        default: tx_state_next = TX_IDLE;
      endcase
    end
  end

  // ---------------- RX deserializer ----------------
  logic [1:0]          rx_sync;
  logic                rx_bit;
  rx_state_t           rx_state, rx_state_next;
  logic [OW-1:0]       rx_cnt, rx_cnt_next;
  logic [BW-1:0]       rx_idx, rx_idx_next;
  logic [DATA_BIT-1:0] rx_shift, rx_shift_next;
  logic                rx_commit;

  assign rx_bit = rx_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_serial};
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      rx_idx   <= rx_idx_next;
      rx_shift <= rx_shift_next;
      // A fresh byte wins over consumption, so overrun keeps rx_valid high.
      if (rx_commit) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_idx_next   = rx_idx;
    rx_shift_next = rx_shift;
    rx_commit     = 1'b0;
    if (tick) begin
      unique case (rx_state)
        RX_IDLE: begin
          if (!rx_bit) begin
            rx_cnt_next   = '0;
            rx_state_next = RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == OS_HALF) begin
            rx_cnt_next   = '0;
            rx_idx_next   = '0;
            rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_next = rx_cnt + OW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == OS_LAST) begin
            rx_cnt_next   = '0;
            rx_shift_next = {rx_bit, rx_shift[DATA_BIT-1:1]};
            if (rx_idx == BIT_LAST) rx_state_next = RX_STOP;
            else                    rx_idx_next   = rx_idx + BW'(1);
          end else begin
            rx_cnt_next = rx_cnt + OW'(1);
          end
        end
        RX_STOP: begin
          // Leave at the stop-bit centre so a following start edge is caught.
          if (rx_cnt == OS_LAST) begin
            rx_cnt_next   = '0;
            rx_commit     = rx_bit;
            rx_state_next = RX_IDLE;
          end else begin
            rx_cnt_next = rx_cnt + OW'(1);
          end
        end
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_uart.sv
// Scoreboard testbench for top_uart: loopback and directly driven RX frames,
// FIFO full behaviour, RX hold/overrun, glitch, framing error and mid-frame reset.
module tb_top_uart;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);  // 27
  localparam int BIT_CLK    = TICK_DIV * OVERSAMPLE;               // 432
  localparam int FRAME_CLK  = 10 * BIT_CLK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_ready = 1'b1;
  logic       loopback = 1'b1;
  logic       rx_drive = 1'b1;
  logic       rx_serial;
  logic       tx_ready, rx_valid, tx_serial;
  logic [7:0] rx_data;

  assign rx_serial = loopback ? tx_serial : rx_drive;

  top_uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE),
    .DATA_BIT  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_serial(tx_serial),
    .rx_serial(rx_serial)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_rx = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  int         rx_cyc [$];

  // Clock edges since reset release; the tick generator restarts with it.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every RX handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      n_rx++;
      rx_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_byte: actual=0x%0h expected=none (t=%0t)", rx_data, $time);
      end else begin
        check("rx_byte", rx_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Move to a point well clear of the next tick so short push bursts are not popped.
  task automatic wait_safe();
    while (!((cyc % TICK_DIV) >= 2 && (cyc % TICK_DIV) <= 15)) step(1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    step(1);
    tx_valid = 1'b0;
    tx_data  = ~b;  // later changes must not alter the queued byte
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drive = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drive = b[i];
      step(BIT_CLK);
    end
    rx_drive = stop;
    step(BIT_CLK);
    rx_drive = 1'b1;
  endtask

  task automatic wait_rx(input int target, input int budget);
    int g = 0;
    while (n_rx < target && g < budget) begin
      step(1);
      g++;
    end
  endtask

  initial begin
    #(150_000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] a5_line;
    logic [7:0] burst [4];
    int         start, bad, g;

    a5_line  = 10'b11_0100_1010;  // start, A5 LSB first, stop: read from bit 0
    burst[0] = 8'hA5;
    burst[1] = 8'h5A;
    burst[2] = 8'hFF;
    burst[3] = 8'h00;

    // 1. Reset values, then an idle line for 20000 clk.
    step(3);
    check("reset_tx_serial", tx_serial, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      step(1);
      if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) bad++;
    end
    check("idle_violations", bad, 0);

    // 2. Loopback of one byte: line waveform and a single received pulse.
    wait_safe();
    check("t2_ready", tx_ready, 1);
    start = n_rx;
    exp_q.push_back(8'hA5);
    push_byte(8'hA5);
    g = 0;
    while (tx_serial !== 1'b0 && g < 200) begin
      step(1);
      g++;
    end
    check("t2_start_seen", tx_serial, 0);
    step(BIT_CLK / 2);
    for (int k = 0; k < 10; k++) begin
      check("t2_line_bit", tx_serial, a5_line[k]);
      step(BIT_CLK);
    end
    wait_rx(start + 1, 10000 - 10 * BIT_CLK - g);
    check("t2_rx_count", n_rx - start, 1);
    step(300);
    check("t2_rx_single_pulse", n_rx - start, 1);

    // 3/4. Four back-to-back pushes fill the FIFO; a fifth is ignored.
    rx_cyc.delete();
    start = n_rx;
    wait_safe();
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_before_push", tx_ready, 1);
      exp_q.push_back(burst[i]);
      push_byte(burst[i]);
    end
    check("t3_ready_low_full", tx_ready, 0);
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    step(1);
    tx_valid = 1'b0;
    g = 0;
    while (tx_ready !== 1'b1 && g < 2 * TICK_DIV) begin
      step(1);
      g++;
    end
    check("t4_ready_after_pop", tx_ready, 1);
    wait_rx(start + 4, 5 * FRAME_CLK);
    step(FRAME_CLK + 200);
    check("t4_rx_count", n_rx - start, 4);
    if (rx_cyc.size() >= 4)
      for (int i = 1; i < 4; i++)
        check("t3_frame_interval", rx_cyc[i] - rx_cyc[i-1], FRAME_CLK);

    // 5. Hold with rx_ready low, then overrun, then release.
    loopback = 1'b0;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    step(100);
    check("t5_valid_first", rx_valid, 1);
    check("t5_data_first", rx_data, 8'h3C);
    step(500);
    check("t5_valid_held", rx_valid, 1);
    send_frame(8'hC3, 1'b1);
    step(100);
    check("t5_valid_overrun", rx_valid, 1);
    check("t5_data_overrun", rx_data, 8'hC3);
    start = n_rx;
    exp_q.push_back(8'hC3);
    rx_ready = 1'b1;
    step(1);
    check("t5_valid_cleared", rx_valid, 0);
    check("t5_rx_count", n_rx - start, 1);

    // 6a. Short low glitch is rejected.
    start = n_rx;
    rx_drive = 1'b0;
    step(200);
    rx_drive = 1'b1;
    step(1000);
    check("t6_glitch_count", n_rx - start, 0);
    check("t6_glitch_valid", rx_valid, 0);

    // 6b. Framing error discarded; next good frame held for the reset test.
    send_frame(8'h55, 1'b0);
    step(1000);
    check("t6_frame_err_count", n_rx - start, 0);
    check("t6_frame_err_valid", rx_valid, 0);
    rx_ready = 1'b0;
    send_frame(8'h81, 1'b1);
    step(100);
    check("t6_good_valid", rx_valid, 1);
    check("t6_good_data", rx_data, 8'h81);

    // 6c. Reset in the middle of an incoming frame with a full TX FIFO.
    rx_drive = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_drive = 8'h42 >> i;
      step(BIT_CLK);
    end
    wait_safe();
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    check("t6_fifo_full", tx_ready, 0);
    rst_n = 1'b0;
    step(2);
    check("t6_rst_tx_serial", tx_serial, 1);
    check("t6_rst_tx_ready", tx_ready, 1);
    check("t6_rst_rx_valid", rx_valid, 0);
    check("t6_rst_rx_data", rx_data, 0);
    rx_drive = 1'b1;
    step(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4 * TICK_DIV; i++) begin
      step(1);
      if (tx_serial !== 1'b1) bad++;
    end
    check("t6_fifo_flushed", bad, 0);
    rx_ready = 1'b1;
    start = n_rx;
    exp_q.push_back(8'h24);
    send_frame(8'h24, 1'b1);
    wait_rx(start + 1, 500);
    check("t6_post_reset_count", n_rx - start, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
